// File: rtl/code_capture_fifo_if.sv
// Code capture handshake bundle: sample strobe/code in, valid/ready code out.
// slave  = the FIFO (consumes in_*, produces out_valid/out_code).
// master = the surrounding logic (drives in_* and out_ready).
interface code_capture_fifo_if #(
    parameter int unsigned CODE_W = 5
);
    logic              in_valid;
    logic [CODE_W-1:0] in_code;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;

    modport slave (
        input  in_valid,
        input  in_code,
        input  out_ready,
        output out_valid,
        output out_code
    );

    modport master (
        output in_valid,
        output in_code,
        output out_ready,
        input  out_valid,
        input  out_code
    );
endinterface

// File: rtl/code_capture_fifo.sv
// code_capture_fifo: samples the tutorial block's code on in_valid into a
// small first-word-fall-through FIFO, read out over valid/ready, with a
// sticky overflow flag and a saturating drop counter.
// Optional build macro CODE_ONLY_CHANGE_EN: only push a code when it differs
// from the previously sampled one (the first sample after reset always pushes).
module code_capture_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned CODE_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    code_capture_fifo_if.slave bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
`ifdef CODE_ONLY_CHANGE_EN
    logic [CODE_W-1:0] last_code_q, last_code_d;
    logic              have_last_q, have_last_d;
`endif

    logic push_req;
    logic pop;
    logic push_ok;
    logic drop;

    // Handshake decode and next-state computation for pointers, count and status
    always_comb begin
`ifdef CODE_ONLY_CHANGE_EN
        push_req    = bus.in_valid && (!have_last_q || (bus.in_code != last_code_q));
        last_code_d = bus.in_valid ? bus.in_code : last_code_q;
        have_last_d = have_last_q | bus.in_valid;
`else
        push_req    = bus.in_valid;
`endif
        pop     = !empty_q && bus.out_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle
        push_ok = push_req && (!full_q || pop);
        drop    = push_req && full_q && !pop;

        rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);

        overflow_d = overflow_q | drop;
        drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    // Control/status registers; synchronous reset wins over any push or pop
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
`ifdef CODE_ONLY_CHANGE_EN
            last_code_q <= '0;
            have_last_q <= 1'b0;
`endif
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
`ifdef CODE_ONLY_CHANGE_EN
            last_code_q <= last_code_d;
            have_last_q <= have_last_d;
`endif
        end
    end

    // Storage write; contents are not reset, only the pointers/count are
    always_ff @(posedge clock) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= bus.in_code;
        end
    end

    // Fall-through read port and status outputs
    always_comb begin
        bus.out_valid = !empty_q;
        bus.out_code  = empty_q ? '0 : mem_q[rd_ptr_q];
        count         = count_q;
        full          = full_q;
        empty         = empty_q;
        overflow      = overflow_q;
        drop_cnt      = drop_cnt_q;
    end

endmodule

// File: tb/tb_code_capture_fifo.sv
// Bench for code_capture_fifo: directed vector table, multi-cycle corner
// sequences and a randomized run against a queue-based reference model.
module tb_code_capture_fifo;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [7:0] drop_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    code_capture_fifo_if #(.CODE_W(5)) bus ();

    code_capture_fifo #(
        .DEPTH  (4),
        .ADDR_W (2),
        .CODE_W (5)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [4:0] code;
        logic       rdy;
        logic       ev;
        logic [4:0] ecode;
        int         ecnt;
        logic       efull;
        logic       eempty;
        logic       eovf;
        int         edrop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic iv, input logic [4:0] code,
                                input logic rdy, input logic ev, input logic [4:0] ecode,
                                input int ecnt, input logic efull, input logic eempty,
                                input logic eovf, input int edrop);
        vec_t v;
        v.rst = rst; v.iv = iv; v.code = code; v.rdy = rdy;
        v.ev = ev; v.ecode = ecode; v.ecnt = ecnt; v.efull = efull;
        v.eempty = eempty; v.eovf = eovf; v.edrop = edrop;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Drive one cycle's inputs, then let the edge happen and settle.
    task automatic apply(input logic r, input logic iv, input logic [4:0] c, input logic rdy);
        reset         = r;
        bus.in_valid  = iv;
        bus.in_code   = c;
        bus.out_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    // Reference model: a queue of stored codes plus drop bookkeeping.
    int mq[$];
    bit m_ovf;
    int m_drop;
    bit m_have;
    int m_last;

    task automatic model_step(input logic r, input logic iv, input int c, input logic rdy);
        bit pop, preq, was_full;
        if (r) begin
            mq.delete();
            m_ovf  = 0;
            m_drop = 0;
            m_have = 0;
            m_last = 0;
        end else begin
            pop  = (mq.size() > 0) && rdy;
`ifdef CODE_ONLY_CHANGE_EN
            preq = iv && (!m_have || (c != m_last));
            if (iv) begin
                m_last = c;
                m_have = 1;
            end
`else
            preq = iv;
`endif
            was_full = (mq.size() == DEPTH);
            if (pop) void'(mq.pop_front());
            if (preq) begin
                if (!was_full || pop) begin
                    mq.push_back(c);
                end else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        int sz;
        sz = mq.size();
        check({tag, " out_valid"}, int'(bus.out_valid), (sz > 0) ? 1 : 0);
        check({tag, " out_code"},  int'(bus.out_code),  (sz > 0) ? mq[0] : 0);
        check({tag, " count"},     int'(count),         sz);
        check({tag, " full"},      int'(full),          (sz == DEPTH) ? 1 : 0);
        check({tag, " empty"},     int'(empty),         (sz == 0) ? 1 : 0);
        check({tag, " overflow"},  int'(overflow),      int'(m_ovf));
        check({tag, " drop_cnt"},  int'(drop_cnt),      m_drop);
    endtask

    task automatic step_m(input logic r, input logic iv, input int c, input logic rdy);
        model_step(r, iv, c, rdy);
        apply(r, iv, 5'(c), rdy);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.out_ready = 1'b0;

        //           rst iv code   rdy  ev code  cnt full empty ovf drop
`ifdef CODE_ONLY_CHANGE_EN
        tbl.push_back(mk(1, 0, 5'h00, 0, 0, 5'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 5'h00, 0, 0, 5'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 5'h00, 0, 0, 5'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 5'h01, 0, 1, 5'h01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h01, 0, 1, 5'h01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h04, 0, 1, 5'h01, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h04, 0, 1, 5'h01, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h01, 0, 1, 5'h01, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 5'h00, 1, 1, 5'h04, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 5'h00, 1, 1, 5'h01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 5'h00, 1, 0, 5'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 5'h01, 0, 0, 5'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 5'h00, 0, 0, 5'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 5'h00, 0, 1, 5'h00, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h00, 0, 1, 5'h00, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h03, 0, 1, 5'h00, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h05, 0, 1, 5'h00, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h03, 0, 1, 5'h00, 4, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h07, 0, 1, 5'h00, 4, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 5'h07, 0, 1, 5'h00, 4, 1, 0, 1, 1));
`else
        tbl.push_back(mk(1, 0, 5'h00, 0, 0, 5'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 5'h00, 0, 0, 5'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 5'h00, 0, 0, 5'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 5'h01, 0, 1, 5'h01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 5'h00, 1, 0, 5'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 5'h01, 0, 1, 5'h01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h04, 0, 1, 5'h01, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h0A, 0, 1, 5'h01, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h1F, 0, 1, 5'h01, 4, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h02, 0, 1, 5'h01, 4, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 5'h02, 0, 1, 5'h01, 4, 1, 0, 1, 2));
        tbl.push_back(mk(0, 1, 5'h02, 0, 1, 5'h01, 4, 1, 0, 1, 3));
        tbl.push_back(mk(0, 1, 5'h10, 1, 1, 5'h04, 4, 1, 0, 1, 3));
        tbl.push_back(mk(0, 0, 5'h00, 1, 1, 5'h0A, 3, 0, 0, 1, 3));
        tbl.push_back(mk(0, 0, 5'h00, 1, 1, 5'h1F, 2, 0, 0, 1, 3));
        tbl.push_back(mk(0, 0, 5'h00, 1, 1, 5'h10, 1, 0, 0, 1, 3));
        tbl.push_back(mk(1, 1, 5'h07, 1, 0, 5'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 5'h01, 0, 1, 5'h01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h01, 0, 1, 5'h01, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h04, 0, 1, 5'h01, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h04, 0, 1, 5'h01, 4, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5'h01, 0, 1, 5'h01, 4, 1, 0, 1, 1));
`endif

        // Directed vector table
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].iv, tbl[i].code, tbl[i].rdy);
            check($sformatf("vec%0d out_valid", i), int'(bus.out_valid), int'(tbl[i].ev));
            check($sformatf("vec%0d out_code", i),  int'(bus.out_code),  int'(tbl[i].ecode));
            check($sformatf("vec%0d count", i),     int'(count),         tbl[i].ecnt);
            check($sformatf("vec%0d full", i),      int'(full),          int'(tbl[i].efull));
            check($sformatf("vec%0d empty", i),     int'(empty),         int'(tbl[i].eempty));
            check($sformatf("vec%0d overflow", i),  int'(overflow),      int'(tbl[i].eovf));
            check($sformatf("vec%0d drop_cnt", i),  int'(drop_cnt),      tbl[i].edrop);
        end

        // Drop counter saturation: fill, then keep pushing distinct codes while stalled
        step_m(1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step_m(0, 1, 8 + i, 0);
        for (int i = 0; i < 260; i++) step_m(0, 1, 2 + (i % 2), 0);
        check("sat drop_cnt", int'(drop_cnt), 255);
        check("sat overflow", int'(overflow), 1);
        check("sat count", int'(count), DEPTH);
        check("sat head", int'(bus.out_code), 8);
        compare_model("sat");

        // Stalled head must hold while out_ready stays low
        for (int i = 0; i < 3; i++) begin
            step_m(0, 0, 0, 0);
            check($sformatf("hold%0d out_code", i), int'(bus.out_code), 8);
            check($sformatf("hold%0d out_valid", i), int'(bus.out_valid), 1);
        end

        // Reset mid-operation with a push and pop pending clears everything
        step_m(1, 1, 5'h15, 1);
        compare_model("midreset");
        check("midreset drop_cnt", int'(drop_cnt), 0);

        // Randomized run against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic r, iv, rdy;
            int   c;
            r   = ($urandom_range(0, 199) == 0);
            iv  = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < 40);
            c   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                              : int'($urandom_range(0, 3));
            step_m(r, iv, c, rdy);
            compare_model($sformatf("rnd%0d", cyc));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/code_capture_fifo.md
Name: code_capture_fifo

Overview:
- Downstream consumer of the 5-bit `out` code produced by the `tutorial` combinational block.
- Samples the code on a qualifying strobe and buffers it in a small first-word-fall-through FIFO.
- Presents buffered codes to a reader over a valid/ready handshake.
- Tracks overflow, so a lab bench or display stage can drain results at its own pace without losing visibility of dropped samples.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- ADDR_W, 2, pointer width; must equal log2(DEPTH).
- CODE_W, 5, code width; matches the width of `tutorial.out`.

Ports:
- clock  input  1  single rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  sample strobe; in_code is captured when high.
- in_code  input  CODE_W  code from tutorial.out.
- out_valid  output  1  FIFO non-empty; out_code is valid.
- out_ready  input  1  reader accepts the head entry when out_valid && out_ready.
- out_code  output  CODE_W  head-of-FIFO code; 0 when empty.
- count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; a push was dropped since the last reset.
- drop_cnt  output  8  number of dropped pushes; saturates at 255.

Behaviour:
- Only one clock domain exists. All state updates happen on the rising edge of `clock`. Reset is synchronous, active-high, and has priority over every other action.
- Reset values: count=0, rd_ptr=0, wr_ptr=0, out_valid=0, out_code=0, full=0, empty=1, overflow=0, drop_cnt=0, last_code=0, have_last=0. Storage array contents are not reset.
- Qualified push: push_req = in_valid, further gated by CODE_ONLY_CHANGE_EN (see Optional Feature).
- Pop: pop = out_valid && out_ready.
- Push outcomes, by FIFO state when push_req is high:
  - Not full: write mem[wr_ptr] <= in_code, wr_ptr += 1 (wraps modulo DEPTH).
  - Full with pop in the same cycle: push accepted. Both pointers advance and count is unchanged.
  - Full with no pop: push dropped. Set overflow=1. drop_cnt += 1, saturating at 255. Storage and pointers are unchanged.
- Pop effects: rd_ptr += 1 (wraps), count -= 1 unless a simultaneous push is accepted.
- Pop while empty is impossible, because out_valid=0.
- First-word-fall-through timing:
  - A code pushed into an empty FIFO at edge N gives out_valid=1 with out_code equal to that code after edge N. This is one-cycle latency from the in_valid sample.
  - out_code is combinational from mem[rd_ptr], forced to 0 when empty.
- Status outputs: count, full and empty are registered (or derived from registered count) and are consistent in every cycle.
- Pointer wrap: pointers are ADDR_W bits. Full and empty are distinguished by count, not by comparing pointers.
- Stability: out_code and out_valid must not change while out_valid && !out_ready, apart from reset.
- Reset mid-operation: all stored entries are discarded. Any push or pop in the reset cycle is ignored, and outputs return to reset values on the next edge.
- overflow and drop_cnt clear only on reset.

Optional Feature:
- Macro: CODE_ONLY_CHANGE_EN.
- When defined:
  - push_req = in_valid && (!have_last || in_code != last_code).
  - On every in_valid sample: last_code <= in_code and have_last <= 1, whether or not the push was accepted or dropped.
  - The first sample after reset is always a push request.
  - Repeated identical codes are neither pushed nor counted as drops.
- When not defined:
  - push_req = in_valid.
  - last_code and have_last are not implemented.

Test Plan:
- Reset then idle:
  - Stimulus: reset high for 2 cycles, then low.
  - Required: out_valid=0, out_code=5'h00, count=0, empty=1, full=0, overflow=0, drop_cnt=0.
- Single pass-through:
  - Stimulus: in_valid=1 with in_code=5'h01 for one cycle, out_ready=0.
  - Required: next cycle out_valid=1, out_code=5'h01, count=1.
  - Then: out_ready=1 for one cycle, after which out_valid=0 and count=0.
- Fill and order:
  - Stimulus: push 5'h01, 5'h04, 5'h0A, 5'h1F on consecutive cycles with out_ready=0.
  - Required: full=1, count=4.
  - Then: pop four times; out_code sequence must be 01, 04, 0A, 1F, ending with empty=1.
- Overflow:
  - Stimulus: with the FIFO full, push 5'h02 three times with out_ready=0.
  - Required: overflow=1, drop_cnt=3, head still 5'h01, count=4.
- Simultaneous push and pop when full:
  - Stimulus: in_valid=1 with in_code=5'h10 and out_ready=1 in the same cycle.
  - Required: count stays 4, drop_cnt unchanged, 5'h10 is later read out last.
- CODE_ONLY_CHANGE_EN build:
  - Stimulus: sample 5'h01, 5'h01, 5'h04, 5'h04, 5'h01.
  - Required: count=3, FIFO holds 01, 04, 01.
  - Without the macro, the same stimulus gives count=4 with full=1 and drop_cnt=1.
